// File: rtl/ps2_key_if.sv
// Receiver-side handshake and decoded key outputs of the PS/2 key controller.
// The master modport belongs to whoever feeds bytes and reads the key state.
interface ps2_key_if;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_overflow;
  logic       rx_pop;
  logic       jump_held;
  logic       duck_held;
  logic       jump_press;
  logic       duck_press;
  logic       other_press;
  logic [1:0] key;
  logic       ovf_flag;
  logic [3:0] err_cnt;

  modport master (
    output rx_data, rx_ready, rx_overflow,
    input  rx_pop, jump_held, duck_held, jump_press, duck_press,
    input  other_press, key, ovf_flag, err_cnt
  );

  modport slave (
    input  rx_data, rx_ready, rx_overflow,
    output rx_pop, jump_held, duck_held, jump_press, duck_press,
    output other_press, key, ovf_flag, err_cnt
  );
endinterface

// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code decoder: pops bytes from a receiver FIFO, tracks E0/F0 prefixes
// and turns make/break codes of the jump and duck key groups into held/press outputs.
module ps2_key_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  ps2_key_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [6:0]  keys_q, keys_d;
  logic [23:0] to_cnt_q, to_cnt_d;
  logic        rx_pop_q, rx_pop_d;
  logic        jump_held_q, jump_held_d;
  logic        duck_held_q, duck_held_d;
  logic        jump_press_q, jump_press_d;
  logic        duck_press_q, duck_press_d;
  logic        other_press_q, other_press_d;
  logic        ovf_q, ovf_d;
  logic [3:0]  err_q, err_d;

  logic        accept;
  logic        is_make;
  logic [3:0]  lk;

  function automatic logic [3:0] err_inc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  // {hit, bit index}: bits 0..3 are the jump group, 4..6 the duck group
  function automatic logic [3:0] key_lookup(input logic [7:0] b);
    case (b)
      8'h1D:   return {1'b1, 3'd0};
      8'h29:   return {1'b1, 3'd1};
      8'h43:   return {1'b1, 3'd2};
      8'h75:   return {1'b1, 3'd3};
      8'h1B:   return {1'b1, 3'd4};
      8'h42:   return {1'b1, 3'd5};
      8'h72:   return {1'b1, 3'd6};
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic is_silent(input logic [7:0] b);
    return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFE);
  endfunction

  assign accept  = bus.rx_ready && !rx_pop_q;
  assign is_make = (state_q == IDLE) || (state_q == EXT);
  assign lk      = key_lookup(bus.rx_data);

  always_comb begin
    state_d       = state_q;
    keys_d        = keys_q;
    to_cnt_d      = to_cnt_q;
    ovf_d         = ovf_q;
    err_d         = err_q;
    other_press_d = 1'b0;
    rx_pop_d      = accept;

    if (bus.rx_overflow) begin
      // Overflow wins over everything; a byte accepted now is popped but dropped
      ovf_d    = 1'b1;
      keys_d   = '0;
      state_d  = IDLE;
      to_cnt_d = '0;
    end else if (accept) begin
      to_cnt_d = '0;
      state_d  = IDLE;
      if (bus.rx_data == 8'hE0) begin
        if (state_q == IDLE)
          state_d = EXT;
        else if (state_q == EXT || state_q == EXT_BRK)
          err_d = err_inc(err_q);
      end else if (bus.rx_data == 8'hF0) begin
        if (state_q == IDLE)
          state_d = BRK;
        else if (state_q == EXT)
          state_d = EXT_BRK;
        else
          err_d = err_inc(err_q);
      end else if (is_silent(bus.rx_data)) begin
        state_d = IDLE;
      end else if (bus.rx_data == 8'h00 || bus.rx_data == 8'hFF) begin
        err_d  = err_inc(err_q);
        keys_d = '0;
      end else if (lk[3]) begin
        keys_d[lk[2:0]] = is_make;
      end else if (is_make) begin
        other_press_d = 1'b1;
      end
    end else if (state_q != IDLE) begin
      // Stalled prefix: abandon it once the idle budget is used up
      if (to_cnt_q == TO_LAST) begin
        state_d  = IDLE;
        err_d    = err_inc(err_q);
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 24'd1;
      end
    end else begin
      to_cnt_d = '0;
    end

    jump_held_d  = |keys_d[3:0];
    duck_held_d  = |keys_d[6:4];
    jump_press_d = !bus.rx_overflow && jump_held_d && !jump_held_q;
    duck_press_d = !bus.rx_overflow && duck_held_d && !duck_held_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      keys_q        <= '0;
      to_cnt_q      <= '0;
      rx_pop_q      <= 1'b0;
      jump_held_q   <= 1'b0;
      duck_held_q   <= 1'b0;
      jump_press_q  <= 1'b0;
      duck_press_q  <= 1'b0;
      other_press_q <= 1'b0;
      ovf_q         <= 1'b0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      keys_q        <= keys_d;
      to_cnt_q      <= to_cnt_d;
      rx_pop_q      <= rx_pop_d;
      jump_held_q   <= jump_held_d;
      duck_held_q   <= duck_held_d;
      jump_press_q  <= jump_press_d;
      duck_press_q  <= duck_press_d;
      other_press_q <= other_press_d;
      ovf_q         <= ovf_d;
      err_q         <= err_d;
    end
  end

  assign bus.rx_pop      = rx_pop_q;
  assign bus.jump_held   = jump_held_q;
  assign bus.duck_held   = duck_held_q;
  assign bus.jump_press  = jump_press_q;
  assign bus.duck_press  = duck_press_q;
  assign bus.other_press = other_press_q;
  assign bus.key         = {duck_held_q, jump_held_q};
  assign bus.ovf_flag    = ovf_q;
  assign bus.err_cnt     = err_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: expected per-byte results are queued as bytes
// are driven and compared when the controller pops the byte.
module tb_ps2_key_ctrl;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps2_key_if bus();

  ps2_key_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0] key;
    logic       jp;
    logic       dp;
    logic       op;
    logic [3:0] err;
    logic       ovf;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks  = 0;
  int    errors  = 0;
  int    pop_cnt = 0;
  logic  prev_pop = 1'b0;
  exp_t  mon_e, mon_got;
  string mon_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic push(input string tag, input logic [1:0] k, input logic jp, input logic dp,
                      input logic op, input logic [3:0] e, input logic ovf);
    exp_t x;
    x.key = k; x.jp = jp; x.dp = dp; x.op = op; x.err = e; x.ovf = ovf;
    exp_q.push_back(x);
    tag_q.push_back(tag);
  endtask

  task automatic send(input logic [7:0] b, input string tag, input logic [1:0] k, input logic jp,
                      input logic dp, input logic op, input logic [3:0] e, input logic ovf);
    push(tag, k, jp, dp, op, e, ovf);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    @(posedge clk);
    #1 bus.rx_ready = 1'b0;
    @(negedge clk);
    #1;
  endtask

  function automatic logic [13:0] all_outs();
    return {bus.rx_pop, bus.jump_held, bus.duck_held, bus.jump_press, bus.duck_press,
            bus.other_press, bus.key, bus.ovf_flag, bus.err_cnt};
  endfunction

  // Scoreboard: every pop must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_pop) begin
        pop_cnt++;
        chk("pop_spacing", {31'd0, prev_pop}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_pop: observed pop of %0h expected no pop", bus.rx_data);
        end else begin
          mon_e = exp_q.pop_front();
          mon_t = tag_q.pop_front();
          mon_got.key = bus.key;
          mon_got.jp  = bus.jump_press;
          mon_got.dp  = bus.duck_press;
          mon_got.op  = bus.other_press;
          mon_got.err = bus.err_cnt;
          mon_got.ovf = bus.ovf_flag;
          chk(mon_t, {21'd0, mon_got}, {21'd0, mon_e});
          chk({mon_t, "_keymap"}, {30'd0, bus.key}, {30'd0, bus.duck_held, bus.jump_held});
        end
      end else begin
        chk("idle_pulses", {29'd0, bus.jump_press, bus.duck_press, bus.other_press}, 32'd0);
      end
      prev_pop = bus.rx_pop;
    end else begin
      prev_pop = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    rst             = 1'b1;
    bus.rx_data     = 8'h00;
    bus.rx_ready    = 1'b0;
    bus.rx_overflow = 1'b0;
    #1;
    chk("reset_state_t0", {18'd0, all_outs()}, 32'd0);
    repeat (3) @(negedge clk);
    chk("reset_state", {18'd0, all_outs()}, 32'd0);
    rst = 1'b0;

    // Single jump key press and release
    p0 = pop_cnt;
    send(8'h29, "r39_make", 2'b01, 1, 0, 0, 4'd0, 0);
    send(8'hF0, "r39_f0",   2'b01, 0, 0, 0, 4'd0, 0);
    send(8'h29, "r39_brk",  2'b00, 0, 0, 0, 4'd0, 0);
    chk("r39_pops", pop_cnt - p0, 32'd3);

    // Typematic repeat and overlapping keys in one group
    send(8'h1D, "r40_make1", 2'b01, 1, 0, 0, 4'd0, 0);
    send(8'h1D, "r40_rep1",  2'b01, 0, 0, 0, 4'd0, 0);
    send(8'h1D, "r40_rep2",  2'b01, 0, 0, 0, 4'd0, 0);
    send(8'h43, "r40_make2", 2'b01, 0, 0, 0, 4'd0, 0);
    send(8'hF0, "r40_f0",    2'b01, 0, 0, 0, 4'd0, 0);
    send(8'h1D, "r40_brk1",  2'b01, 0, 0, 0, 4'd0, 0);
    send(8'hF0, "r40_f0b",   2'b01, 0, 0, 0, 4'd0, 0);
    send(8'h43, "r40_brk2",  2'b00, 0, 0, 0, 4'd0, 0);

    // Extended codes across both groups
    send(8'hE0, "r41_e0",    2'b00, 0, 0, 0, 4'd0, 0);
    send(8'h72, "r41_duck",  2'b10, 0, 1, 0, 4'd0, 0);
    send(8'h29, "r41_jump",  2'b11, 1, 0, 0, 4'd0, 0);
    send(8'hE0, "r41_e0b",   2'b11, 0, 0, 0, 4'd0, 0);
    send(8'hF0, "r41_f0",    2'b11, 0, 0, 0, 4'd0, 0);
    send(8'h72, "r41_brk",   2'b01, 0, 0, 0, 4'd0, 0);
    send(8'hF0, "r41_f0c",   2'b01, 0, 0, 0, 4'd0, 0);
    send(8'h29, "r41_brk2",  2'b00, 0, 0, 0, 4'd0, 0);

    // Prefix timeout
    send(8'hE0, "r42_e0", 2'b00, 0, 0, 0, 4'd0, 0);
    repeat (10) @(negedge clk);
    chk("r42_before_timeout", {28'd0, bus.err_cnt}, 32'd0);
    repeat (10) @(negedge clk);
    chk("r42_after_timeout", {28'd0, bus.err_cnt}, 32'd1);
    send(8'h75, "r42_make", 2'b01, 1, 0, 0, 4'd1, 0);
    send(8'hF0, "r42_f0",   2'b01, 0, 0, 0, 4'd1, 0);
    send(8'h75, "r42_brk",  2'b00, 0, 0, 0, 4'd1, 0);

    // Silent acknowledge and break of an unmapped key
    send(8'hFA, "fa_silent",     2'b00, 0, 0, 0, 4'd1, 0);
    send(8'hF0, "unmap_f0",      2'b00, 0, 0, 0, 4'd1, 0);
    send(8'h1C, "unmap_brk",     2'b00, 0, 0, 0, 4'd1, 0);

    // Overflow clears held keys and sets the sticky flag
    send(8'h1B, "r43_hold", 2'b10, 0, 1, 0, 4'd1, 0);
    @(negedge clk);
    bus.rx_overflow = 1'b1;
    @(posedge clk);
    #1 bus.rx_overflow = 1'b0;
    @(negedge clk);
    #1;
    chk("r43_duck_cleared", {31'd0, bus.duck_held}, 32'd0);
    chk("r43_ovf_flag", {31'd0, bus.ovf_flag}, 32'd1);
    send(8'h00, "r43_kerr",  2'b00, 0, 0, 0, 4'd2, 1);
    send(8'h1C, "r43_other", 2'b00, 0, 0, 1, 4'd2, 1);

    // Byte accepted on an overflow edge is popped but discarded
    push("ovf_discard", 2'b00, 0, 0, 0, 4'd2, 1);
    @(negedge clk);
    bus.rx_data     = 8'h1D;
    bus.rx_ready    = 1'b1;
    bus.rx_overflow = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_ready    = 1'b0;
    bus.rx_overflow = 1'b0;
    @(negedge clk);
    #1;

    // Continuous rx_ready: one byte per two cycles at most
    p0 = pop_cnt;
    push("r44_e0",  2'b00, 0, 0, 0, 4'd2, 1);
    push("r44_f0",  2'b00, 0, 0, 0, 4'd2, 1);
    push("r44_f0b", 2'b00, 0, 0, 0, 4'd3, 1);
    @(negedge clk);
    bus.rx_data  = 8'hE0;
    bus.rx_ready = 1'b1;
    @(posedge clk);
    #1 bus.rx_data = 8'hF0;
    repeat (4) @(posedge clk);
    #1 bus.rx_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("r44_pops", pop_cnt - p0, 32'd3);
    chk("r44_err", {28'd0, bus.err_cnt}, 32'd3);
    #1 rst = 1'b1;
    #1;
    chk("r44_async_reset", {18'd0, all_outs()}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-prefix discards the E0
    send(8'hE0, "r37_e0", 2'b00, 0, 0, 0, 4'd0, 0);
    @(negedge clk);
    rst = 1'b1;
    #2 rst = 1'b0;
    send(8'hE0, "r37_e0_fresh", 2'b00, 0, 0, 0, 4'd0, 0);
    send(8'h75, "r37_make",     2'b01, 1, 0, 0, 4'd0, 0);

    // Error counter saturation
    for (int i = 0; i < 16; i++) begin
      send(8'hFF, $sformatf("sat_%0d", i), 2'b00, 0, 0, 0,
           (i + 1 > 15) ? 4'd15 : 4'(i + 1), 0);
    end

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_key_ctrl.md
PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2000000: maximum idle cycles allowed inside a prefix sequence.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 rx_data  input  8  scan-code byte at the receiver FIFO head.
REQ-005 rx_ready  input  1  high while rx_data holds an unread byte.
REQ-006 rx_overflow  input  1  receiver FIFO overflow indication.
REQ-007 rx_pop  output  1  one-cycle pulse that pops the receiver FIFO head.
REQ-008 jump_held  output  1  high while any jump key is held.
REQ-009 duck_held  output  1  high while any duck key is held.
REQ-010 jump_press, duck_press  output  1 each  one-cycle pulse when the group goes from not held to held.
REQ-011 other_press  output  1  one-cycle pulse on a make code of an unmapped key.
REQ-012 key  output  2  {duck_held, jump_held}.
REQ-013 ovf_flag  output  1  sticky receiver-overflow flag.
REQ-014 err_cnt  output  4  saturating protocol-error count.

Function
REQ-015 Byte acceptance: at a rising edge with rx_ready=1 and rx_pop=0, the block decodes rx_data and registers rx_pop=1 for the next cycle.
REQ-016 rx_ready is ignored while rx_pop=1, so at most one byte is consumed every 2 cycles.
REQ-017 All outputs are registered; held, press and counter updates appear in the same cycle in which rx_pop is high.
REQ-018 FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
REQ-019 Transitions: from IDLE, E0 goes to EXT and F0 goes to BRK; from EXT, F0 goes to EXT_BRK; any other byte is a code that is applied and returns the FSM to IDLE.
REQ-020 E0 received in EXT or EXT_BRK, or F0 received in BRK or EXT_BRK, is a protocol error: err_cnt increments and the FSM goes to IDLE.
REQ-021 Make codes (IDLE or EXT) set the per-key bit; break codes (BRK or EXT_BRK) clear it.
REQ-022 There are 7 per-key bits.
REQ-023 Jump group: 1D, 29, 43, and 75 (with or without E0).
REQ-024 Duck group: 1B, 42, and 72 (with or without E0).
REQ-025 jump_held and duck_held are the OR of their group's per-key bits; releasing one key while another key in the group is held keeps the group output high.
REQ-026 A press pulse fires only on a 0 to 1 change of the group OR; typematic repeat makes of an already-held key produce no pulse.
REQ-027 other_press pulses on a make of any unmapped code except FA, AA, EE, FE, 00 and FF; breaks of unmapped codes have no effect.
REQ-028 FA, AA, EE and FE are consumed silently and return the FSM to IDLE.
REQ-029 00 and FF are keyboard error codes: err_cnt increments, all per-key bits clear, and the FSM goes to IDLE.
REQ-030 Timeout: a 24-bit counter runs while the FSM is in a non-IDLE state and resets on every accepted byte.
REQ-031 On reaching TIMEOUT_CYCLES-1, the FSM goes to IDLE and err_cnt increments.
REQ-032 err_cnt saturates at 15.
REQ-033 rx_overflow=1 at an edge sets ovf_flag, clears all per-key bits, forces the FSM to IDLE, and suppresses pulses for that edge.
REQ-034 A byte accepted on the same edge as an overflow is still popped but discarded.
REQ-035 A simultaneous timeout and byte acceptance: the byte wins, and the timeout is not counted.

Reset
REQ-036 rst=1 forces the FSM to IDLE and clears the per-key bits, timeout counter, rx_pop, all pulses, key, ovf_flag and err_cnt to 0 immediately, without waiting for a clock edge.
REQ-037 rst asserted mid-sequence (for example after E0) discards the prefix; the first byte after release is decoded from IDLE.
REQ-038 ovf_flag and err_cnt clear only on rst.

Verification
REQ-039 Bytes 29, then F0 29 -> jump_held goes to 1 with a single jump_press pulse, then to 0; key goes 01 then 00; rx_pop pulses exactly 3 times.
REQ-040 Bytes 1D 1D 1D, 43, F0 1D -> one jump_press only; jump_held stays 1 after F0 1D because 43 is still held.
REQ-041 Bytes E0 72, 29, E0 F0 72 -> key goes 10, then 11, then 01; duck_press and jump_press each pulse once.
REQ-042 Bytes E0, then no byte for TIMEOUT_CYCLES cycles (bench TIMEOUT_CYCLES=16), then 75 -> err_cnt=1; 75 is decoded as a non-extended make and jump_held=1.
REQ-043 Hold 1B, pulse rx_overflow, then bytes 00 and 1C -> duck_held goes to 0 and ovf_flag=1; 00 gives err_cnt=1; 1C gives one other_press pulse.
REQ-044 rx_ready held high continuously with bytes E0 F0 F0 -> accepted no more than once every 2 cycles; the second F0 gives err_cnt=1; assert rst afterwards -> all outputs 0 asynchronously.
